// File: rtl/pga_spi_interface.sv
// Write-only serial loader for an SPI programmable-gain amplifier.
// Control advances on rising sck; cs_n/mosi are launched on falling sck so the PGA samples mid-bit.
module pga_spi_interface #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  sck,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] code_i,
  input  logic                  set_i,
  output logic                  ready_o,
  output logic                  cs_n,
  output logic                  mosi
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    END
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] sreg;
  logic [CNT_W-1:0]      cnt;

  // Rising edge: frame sequencing, code capture and bit advance
  always_ff @(posedge sck) begin
    if (rst) begin
      state   <= IDLE;
      ready_o <= 1'b1;
      sreg    <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          ready_o <= 1'b1;
          if (set_i) begin
            sreg    <= code_i;
            cnt     <= CNT_W'(DATA_WIDTH - 1);
            ready_o <= 1'b0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          // The PGA has just sampled the current MSB; the last bit needs no shift.
          if (cnt == '0) begin
            state <= END;
          end else begin
            sreg <= sreg << 1;
            cnt  <= cnt - CNT_W'(1);
          end
        end
        END: begin
          state   <= IDLE;
          ready_o <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          ready_o <= 1'b1;
        end
      endcase
    end
  end

  // Falling edge: launch pin values half a period ahead of the PGA sample
  always_ff @(negedge sck) begin
    if (rst) begin
      cs_n <= 1'b1;
      mosi <= 1'b0;
    end else begin
      cs_n <= (state != SHIFT);
      mosi <= (state == SHIFT) ? sreg[DATA_WIDTH-1] : 1'b0;
    end
  end

endmodule

// File: tb/tb_pga_spi_interface.sv
// Directed bench for pga_spi_interface: captures mosi at each rising sck like the PGA
// and compares each frame against the hand-written code.
module tb_pga_spi_interface;

  logic       sck;
  logic       rst;
  logic [7:0] code_i;
  logic       set_i;
  logic       ready_o;
  logic       cs_n;
  logic       mosi;

  int tests = 0;
  int fails = 0;

  pga_spi_interface #(.DATA_WIDTH(8)) dut (
    .sck    (sck),
    .rst    (rst),
    .code_i (code_i),
    .set_i  (set_i),
    .ready_o(ready_o),
    .cs_n   (cs_n),
    .mosi   (mosi)
  );

  initial sck = 1'b0;
  always #5 sck = ~sck;

  task automatic step();
    @(posedge sck);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Collect eight bits as the PGA would; optionally poke a busy-time request at bit 'poke'.
  task automatic capture(input string tag, input int poke, output logic [7:0] got);
    got = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (i == poke) begin
        set_i  = 1'b1;
        code_i = 8'h00;
      end
      step();
      if (i == poke) set_i = 1'b0;
      chk({tag, "_csn_low"}, 32'(cs_n), 32'd0);
      got = {got[6:0], mosi};
    end
  endtask

  task automatic write(input string tag, input logic [7:0] code, input int poke);
    logic [7:0] got;
    code_i = code;
    set_i  = 1'b1;
    step();
    set_i = 1'b0;
    chk({tag, "_accept_ready"}, 32'(ready_o), 32'd0);
    chk({tag, "_accept_csn"}, 32'(cs_n), 32'd1);
    @(negedge sck);
    #1;
    chk({tag, "_f0_csn"}, 32'(cs_n), 32'd0);
    capture(tag, poke, got);
    chk({tag, "_data"}, 32'(got), 32'(code));
    chk({tag, "_r8_ready"}, 32'(ready_o), 32'd0);
    step();
    chk({tag, "_r9_ready"}, 32'(ready_o), 32'd1);
    chk({tag, "_end_csn"}, 32'(cs_n), 32'd1);
    chk({tag, "_end_mosi"}, 32'(mosi), 32'd0);
  endtask

  initial begin
    logic [7:0] got;
    rst    = 1'b1;
    set_i  = 1'b0;
    code_i = 8'h00;

    // Reset
    step();
    step();
    rst = 1'b0;
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_csn", 32'(cs_n), 32'd1);
    chk("rst_mosi", 32'(mosi), 32'd0);
    step();
    step();
    chk("idle_csn", 32'(cs_n), 32'd1);
    chk("idle_ready", 32'(ready_o), 32'd1);

    // Basic write
    write("basic", 8'h8F, -1);

    // Busy ignore: a request at bit 3 must neither corrupt nor queue
    write("busy", 8'h8F, 3);
    step();
    chk("busy_noq_ready", 32'(ready_o), 32'd1);
    step();
    chk("busy_noq_csn", 32'(cs_n), 32'd1);
    chk("busy_noq_ready2", 32'(ready_o), 32'd1);

    // Back-to-back with set_i held; code change after acceptance must not leak in
    code_i = 8'hA5;
    set_i  = 1'b1;
    step();
    chk("b2b_acc1_ready", 32'(ready_o), 32'd0);
    code_i = 8'h3C;
    capture("b2b1", -1, got);
    chk("b2b1_data", 32'(got), 32'hA5);
    step();
    chk("b2b_gap_ready", 32'(ready_o), 32'd1);
    chk("b2b_gap_csn", 32'(cs_n), 32'd1);
    step();
    set_i = 1'b0;
    chk("b2b_acc2_ready", 32'(ready_o), 32'd0);
    chk("b2b_acc2_csn", 32'(cs_n), 32'd1);
    capture("b2b2", -1, got);
    chk("b2b2_data", 32'(got), 32'h3C);
    step();
    chk("b2b2_ready", 32'(ready_o), 32'd1);
    chk("b2b2_csn", 32'(cs_n), 32'd1);

    // Reset and set on the same edge: no frame
    rst    = 1'b1;
    set_i  = 1'b1;
    code_i = 8'hFF;
    step();
    rst   = 1'b0;
    set_i = 1'b0;
    chk("rstset_ready", 32'(ready_o), 32'd1);
    step();
    chk("rstset_csn", 32'(cs_n), 32'd1);
    chk("rstset_ready2", 32'(ready_o), 32'd1);

    // Reset mid-frame after the 4th bit of 8'hFF
    code_i = 8'hFF;
    set_i  = 1'b1;
    step();
    set_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("abort_bit", 32'(mosi), 32'd1);
    end
    rst = 1'b1;
    @(negedge sck);
    #1;
    chk("abort_csn", 32'(cs_n), 32'd1);
    chk("abort_mosi", 32'(mosi), 32'd0);
    step();
    chk("abort_ready", 32'(ready_o), 32'd1);
    rst = 1'b0;
    step();
    chk("abort_idle_csn", 32'(cs_n), 32'd1);
    write("after_abort", 8'h81, -1);

    // Bit patterns
    write("pat00", 8'h00, -1);
    write("patFF", 8'hFF, -1);
    write("pat01", 8'h01, -1);
    write("pat80", 8'h80, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
